// File: rtl/ssd_scan_reader.sv
// Loopback reader for a multiplexed active-low seven-segment bus: synchronizes the pins,
// waits for each digit slot to settle, then decodes the glyph back into a per-digit nibble.
module ssd_scan_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  update,
  output logic                  frame_done
);

  localparam int SW = DIGITS + 7;
  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;

  typedef enum logic {SETTLE, HELD} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [SW-1:0]          s1_q, s_q, prev_q;
  logic [4*DIGITS-1:0]    value_q;
  logic [DIGITS-1:0]      valid_q, err_q, seen_q;
  logic                   update_q, frame_q;

  logic [DIGITS-1:0]      an_act;
  logic [6:0]             seg_p;
  logic                   one_hot, same, capture;
  logic [4:0]             dec;

  // {hit, nibble} for an active-high gfedcba pattern; blank and non-glyphs miss
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 5'h10;
      7'h06: decode = 5'h11;
      7'h5B: decode = 5'h12;
      7'h4F: decode = 5'h13;
      7'h66: decode = 5'h14;
      7'h6D: decode = 5'h15;
      7'h7D: decode = 5'h16;
      7'h07: decode = 5'h17;
      7'h7F: decode = 5'h18;
      7'h6F: decode = 5'h19;
      7'h77: decode = 5'h1A;
      7'h7C: decode = 5'h1B;
      7'h39: decode = 5'h1C;
      7'h5E: decode = 5'h1D;
      7'h79: decode = 5'h1E;
      7'h71: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  // Pins are asynchronous; idle bus (all ones) is the reset value of every stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '1;
      s_q    <= '1;
      prev_q <= '1;
    end else begin
      s1_q   <= {an_n, seg_n};
      s_q    <= s1_q;
      prev_q <= s_q;
    end
  end

  assign an_act  = ~s_q[SW-1:7];
  assign seg_p   = ~s_q[6:0];
  assign one_hot = (an_act != '0) && ((an_act & (an_act - DIGITS'(1))) == '0);
  assign same    = (s_q == prev_q);
  assign dec     = decode(seg_p);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SETTLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    capture = 1'b0;
    if (!same) begin
      state_d = SETTLE;
      count_d = '0;
    end else if (state_q == SETTLE) begin
      count_d = count_q + CW'(1);
      if (count_d == CW'(STABLE_CYCLES - 1)) begin
        state_d = HELD;
        capture = one_hot;
      end
    end
    if (clr) begin
      state_d = SETTLE;
      count_d = '0;
      capture = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      valid_q <= '0;
      err_q   <= '0;
    end else if (clr) begin
      value_q <= '0;
      valid_q <= '0;
      err_q   <= '0;
    end else if (capture) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (an_act[i]) begin
          if (dec[4]) value_q[4*i +: 4] <= dec[3:0];
          valid_q[i] <= dec[4];
          err_q[i]   <= ~dec[4];
        end
      end
    end
  end

  // The completing capture closes the frame, so seen restarts empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q   <= '0;
      update_q <= 1'b0;
      frame_q  <= 1'b0;
    end else if (clr) begin
      seen_q   <= '0;
      update_q <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      update_q <= capture;
      frame_q  <= 1'b0;
      if (capture) begin
        if ((seen_q | an_act) == '1) begin
          frame_q <= 1'b1;
          seen_q  <= '0;
        end else begin
          seen_q  <= seen_q | an_act;
        end
      end
    end
  end

  assign value       = value_q;
  assign digit_valid = valid_q;
  assign digit_err   = err_q;
  assign update      = update_q;
  assign frame_done  = frame_q;

endmodule

// File: tb/tb_ssd_scan_reader.sv
// Bench for ssd_scan_reader: table vectors, hand sequences for glitch/clr/reset,
// and random bus traffic, all checked every cycle against a run-length reference model.
module tb_ssd_scan_reader;
  localparam int D  = 4;
  localparam int ST = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic [6:0]   seg_n = '1;
  logic [D-1:0] an_n = '1;
  logic [4*D-1:0] value;
  logic [D-1:0] digit_valid, digit_err;
  logic         update, frame_done;

  ssd_scan_reader #(.DIGITS(D), .STABLE_CYCLES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n), .clr(clr),
    .value(value), .digit_valid(digit_valid), .digit_err(digit_err),
    .update(update), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // reference model: synchronized-sample history and the length of its current run
  logic [10:0]  y_cur, x_prev;
  int           run;
  logic [15:0]  m_val;
  logic [3:0]   m_vld, m_err, m_seen;
  logic         m_upd, m_fd;
  int           n_upd, n_fd, first_upd, edge_no;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          hold;
    int          upd_at;
    logic [15:0] val;
    logic [3:0]  vld;
    logic [3:0]  err;
    logic        fd;
  } vec_t;
  vec_t tbl [11];

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (glyph[i] == p) return i;
    return -1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    y_cur = '1; x_prev = '1; run = 2;
    m_val = '0; m_vld = '0; m_err = '0; m_seen = '0; m_upd = 1'b0; m_fd = 1'b0;
  endtask

  task automatic step();
    logic [10:0] y_next;
    logic [3:0]  act;
    int          n;
    @(posedge clk);
    edge_no++;
    act = ~y_cur[10:7];
    m_upd = 1'b0;
    m_fd  = 1'b0;
    if (clr) begin
      m_val = '0; m_vld = '0; m_err = '0; m_seen = '0;
    end else if (run == ST && $countones(act) == 1) begin
      m_upd = 1'b1;
      n = lookup(~y_cur[6:0]);
      for (int i = 0; i < D; i++) begin
        if (act[i]) begin
          if (n >= 0) begin
            m_val[4*i +: 4] = n[3:0];
            m_vld[i] = 1'b1;
            m_err[i] = 1'b0;
          end else begin
            m_vld[i] = 1'b0;
            m_err[i] = 1'b1;
          end
        end
      end
      if ((m_seen | act) == 4'hF) begin
        m_fd = 1'b1;
        m_seen = '0;
      end else begin
        m_seen = m_seen | act;
      end
    end
    y_next = x_prev;
    x_prev = {an_n, seg_n};
    if (clr) run = (y_next == y_cur) ? 2 : 1;
    else     run = (y_next == y_cur) ? run + 1 : 1;
    y_cur = y_next;
    #1;
    check("cycle", {6'd0, value, digit_valid, digit_err, update, frame_done},
                   {6'd0, m_val, m_vld, m_err, m_upd, m_fd});
    if (update) begin
      n_upd++;
      if (first_upd == 0) first_upd = edge_no;
    end
    if (frame_done) n_fd++;
  endtask

  task automatic hold_pins(input logic [3:0] a, input logic [6:0] s, input int cyc);
    an_n = a; seg_n = s;
    for (int k = 0; k < cyc; k++) step();
  endtask

  task automatic clear_counts();
    n_upd = 0; n_fd = 0; first_upd = 0; edge_no = 0;
  endtask

  initial begin
    tbl[0]  = '{4'b1110, 7'h30, 10, 6, 16'h0003, 4'b0001, 4'b0000, 1'b0};
    tbl[1]  = '{4'b1110, 7'h40, 10, 6, 16'h0000, 4'b0001, 4'b0000, 1'b0};
    tbl[2]  = '{4'b1101, 7'h79, 10, 6, 16'h0010, 4'b0011, 4'b0000, 1'b0};
    tbl[3]  = '{4'b1011, 7'h24, 10, 6, 16'h0210, 4'b0111, 4'b0000, 1'b0};
    tbl[4]  = '{4'b0111, 7'h08, 10, 6, 16'hA210, 4'b1111, 4'b0000, 1'b1};
    tbl[5]  = '{4'b1100, 7'h08, 20, 0, 16'hA210, 4'b1111, 4'b0000, 1'b0};
    tbl[6]  = '{4'b1111, 7'h08, 20, 0, 16'hA210, 4'b1111, 4'b0000, 1'b0};
    tbl[7]  = '{4'b1011, 7'h12, 10, 6, 16'hA510, 4'b1111, 4'b0000, 1'b0};
    tbl[8]  = '{4'b1011, 7'h36, 10, 6, 16'hA510, 4'b1011, 4'b0100, 1'b0};
    tbl[9]  = '{4'b1011, 7'h7F, 10, 6, 16'hA510, 4'b1011, 4'b0100, 1'b0};
    tbl[10] = '{4'b1011, 7'h02, 10, 6, 16'hA610, 4'b1111, 4'b0000, 1'b0};

    model_reset();
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {6'd0, value, digit_valid, digit_err, update, frame_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[t]) begin
      clear_counts();
      hold_pins(tbl[t].an, tbl[t].seg, tbl[t].hold);
      check($sformatf("tbl%0d_upd_at", t), first_upd, tbl[t].upd_at);
      check($sformatf("tbl%0d_n_upd", t), n_upd, (tbl[t].upd_at != 0) ? 1 : 0);
      check($sformatf("tbl%0d_state", t), {4'd0, value, digit_valid, digit_err},
                                           {4'd0, tbl[t].val, tbl[t].vld, tbl[t].err});
      check($sformatf("tbl%0d_fd", t), n_fd, tbl[t].fd ? 1 : 0);
    end

    // glitch: a 2-cycle excursion never captures, only the settled '7'
    clear_counts();
    hold_pins(4'b1110, 7'h78, 3);
    hold_pins(4'b1110, 7'h79, 2);
    hold_pins(4'b1110, 7'h78, 10);
    check("glitch_n_upd", n_upd, 1);
    check("glitch_digit0", value[3:0], 4'h7);

    // clr landing on the capture edge
    clear_counts();
    hold_pins(4'b1101, 7'h10, 5);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_on_capture", {6'd0, value, digit_valid, digit_err, update, frame_done}, 32'd0);
    clear_counts();
    hold_pins(4'b1101, 7'h10, 6);
    check("post_clr_value", {12'd0, value, digit_valid}, {12'd0, 16'h0090, 4'b0010});
    clear_counts();
    hold_pins(4'b1110, 7'h40, 10);
    hold_pins(4'b1011, 7'h40, 10);
    check("post_clr_no_fd_yet", n_fd, 0);
    hold_pins(4'b0111, 7'h40, 10);
    check("post_clr_fd", n_fd, 1);

    // asynchronous reset mid-SETTLE
    an_n = 4'b1101; seg_n = 7'h40;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("rst_mid", {6'd0, value, digit_valid, digit_err, update, frame_done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    clear_counts();
    hold_pins(4'b1101, 7'h40, 10);
    hold_pins(4'b1110, 7'h06 ^ 7'h7F, 10);
    hold_pins(4'b1011, 7'h40, 10);
    check("rst_frame_partial", n_fd, 0);
    hold_pins(4'b0111, 7'h40, 10);
    check("rst_frame_fd", n_fd, 1);
    check("rst_frame_n_upd", n_upd, 4);

    // random bus traffic against the model
    for (int it = 0; it < 300; it++) begin
      logic [3:0] a;
      logic [6:0] s;
      case ($urandom_range(0, 5))
        0:       a = 4'b1111;
        1:       a = 4'($urandom);
        default: a = ~(4'b0001 << $urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 3) == 0) s = 7'($urandom);
      else                           s = ~glyph[$urandom_range(0, 15)];
      an_n = a; seg_n = s;
      clr = ($urandom_range(0, 24) == 0);
      step();
      clr = 1'b0;
      repeat ($urandom_range(0, 9)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
